// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register slice (package riscv_defines).
// WORD_WIDTH sets the width of every operand lane and forwarding source.
// pipe_state_t names the three occupancy states of the stage.
package riscv_defines;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and data bus of one pipeline stage register.
// The slave modport is the stage itself. The master modport is the
// environment that drives the upstream beat and the downstream ready.
interface pipe_stage_reg_if
  import riscv_defines::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_OPS    = 2,
  parameter int NUM_FWD    = 2
) ();

  logic                                 valid_i;
  logic                                 ready_o;
  logic [DATA_WIDTH-1:0]                payload_i;
  logic [NUM_OPS-1:0][WORD_WIDTH-1:0]   op_i;
  logic [NUM_FWD-1:0][WORD_WIDTH-1:0]   fwd_data_i;
  logic [NUM_OPS-1:0][NUM_FWD-1:0]      fwd_sel_i;
  logic                                 flush_i;
  logic                                 valid_o;
  logic                                 ready_i;
  logic [DATA_WIDTH-1:0]                payload_o;
  logic [NUM_OPS-1:0][WORD_WIDTH-1:0]   op_o;

  modport slave (
    input  valid_i, payload_i, op_i, fwd_data_i, fwd_sel_i, flush_i, ready_i,
    output ready_o, valid_o, payload_o, op_o
  );

  modport master (
    output valid_i, payload_i, op_i, fwd_data_i, fwd_sel_i, flush_i, ready_i,
    input  ready_o, valid_o, payload_o, op_o
  );

endinterface

// File: rtl/pipe_fwd_mux.sv
// Priority operand select for one lane.
// The lowest set bit of sel picks the matching forwarding source, where index 0
// is the youngest producer. When no select bit is set, the register-file operand
// passes through unchanged.
module pipe_fwd_mux
  import riscv_defines::*;
#(
  parameter int NUM_FWD = 2
) (
  input  logic [NUM_FWD-1:0]                 sel,
  input  logic [NUM_FWD-1:0][WORD_WIDTH-1:0] fwd_data,
  input  logic [WORD_WIDTH-1:0]              op,
  output logic [WORD_WIDTH-1:0]              res
);

  // Scan from the oldest source down to the youngest, so the lowest set index wins.
  always_comb begin
    // NOTE: res is assigned first on every path, so no latch is inferred.
    res = op;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (sel[k]) res = fwd_data[k];
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer and operand forwarding.
// The main register drives the outputs. The skid register absorbs one beat when
// downstream stalls, which lets ready_o be a registered signal.
// Operands are resolved against the forwarding network at capture time only.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import riscv_defines::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_OPS    = 2,
  parameter int NUM_FWD    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_stage_reg_if.slave bus,
  output logic [31:0]   stall_cnt_o,
  output logic [31:0]   flush_cnt_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]              payload;
    logic [NUM_OPS-1:0][WORD_WIDTH-1:0] ops;
  } beat_t;

  pipe_state_t state_q, state_d;
  beat_t       main_q, skid_q, in_beat;
  logic        valid_q, ready_q;
  logic        load_main, load_skid, move_skid;
  logic [NUM_OPS-1:0][WORD_WIDTH-1:0] resolved_ops;

  for (genvar lane = 0; lane < NUM_OPS; lane++) begin : g_lane
    pipe_fwd_mux #(
      .NUM_FWD (NUM_FWD)
    ) u_fwd_mux (
      .sel      (bus.fwd_sel_i[lane]),
      .fwd_data (bus.fwd_data_i),
      .op       (bus.op_i[lane]),
      .res      (resolved_ops[lane])
    );
  end

  assign in_beat.payload = bus.payload_i;
  assign in_beat.ops     = resolved_ops;

  // Compute the next occupancy state and which register captures this cycle.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (bus.valid_i) begin
          load_main = 1'b1;
          state_d   = FULL;
        end
      end
      FULL: begin
        if (bus.valid_i && bus.ready_i) begin
          load_main = 1'b1;
        end else if (bus.valid_i && !bus.ready_i) begin
          load_skid = 1'b1;
          state_d   = SKID;
        end else if (!bus.valid_i && bus.ready_i) begin
          state_d   = EMPTY;
        end
      end
      SKID: begin
        if (bus.ready_i) begin
          move_skid = 1'b1;
          state_d   = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A flush overrides every transition and drops the incoming beat.
    if (bus.flush_i) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  // Hold the state and the registered handshake outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so all flops update together.
    if (!rst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != SKID);
    end
  end

  // Capture data into main and skid. A stalled beat keeps its captured value.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset so that outputs and skid contents read as zero
    // after reset, not as stale or unknown values.
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)      main_q <= in_beat;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_beat;
    end
  end

  assign bus.valid_o   = valid_q;
  assign bus.ready_o   = ready_q;
  assign bus.payload_o = main_q.payload;
  assign bus.op_o      = main_q.ops;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall_evt, flush_evt;

  assign stall_evt = valid_q && !bus.ready_i;
  assign flush_evt = bus.flush_i && (valid_q || bus.valid_i);

  // Count stall cycles and flushes that discard a beat. Both counters saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg.
// The reference model treats the stage as a FIFO of at most two beats. Operands
// are resolved when a beat is pushed. Directed scenarios are followed by
// randomized traffic.
module tb_pipe_stage_reg;
  import riscv_defines::*;

  localparam int DW = 64;
  localparam int NO = 2;
  localparam int NF = 2;

  typedef struct packed {
    logic [DW-1:0]              payload;
    logic [NO-1:0][WORD_WIDTH-1:0] ops;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_stage_reg_if #(.DATA_WIDTH(DW), .NUM_OPS(NO), .NUM_FWD(NF)) bus ();

  pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_OPS(NO), .NUM_FWD(NF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  beat_t       mq[$];
  logic [63:0] seen[$];
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Isolate the lowest set select bit arithmetically, then pick the matching source.
  function automatic logic [WORD_WIDTH-1:0] resolve(input logic [NF-1:0] sel,
                                                    input logic [NF-1:0][WORD_WIDTH-1:0] fwd,
                                                    input logic [WORD_WIDTH-1:0] op);
    logic [NF-1:0] low;
    low = sel & (~sel + 1'b1);
    for (int k = 0; k < NF; k++) begin
      if (low == (NF'(1) << k)) return fwd[k];
    end
    return op;
  endfunction

  task automatic compare_outputs();
    check("valid_o", 64'(bus.valid_o), 64'(mq.size() > 0));
    check("ready_o", 64'(bus.ready_o), 64'(mq.size() < 2));
    if (mq.size() > 0) begin
      check("payload_o", bus.payload_o, mq[0].payload);
      for (int l = 0; l < NO; l++) check("op_o", 64'(bus.op_o[l]), 64'(mq[0].ops[l]));
    end
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`else
    check("stall_cnt", 64'(stall_cnt), 64'd0);
    check("flush_cnt", 64'(flush_cnt), 64'd0);
`endif
  endtask

  // Drive one cycle of stimulus, advance the model, then compare just after the edge.
  task automatic cycle(input logic v, input logic [63:0] pl, input logic rdy, input logic fl);
    beat_t nb;
    logic  acc, pop;
    bus.valid_i   = v;
    bus.payload_i = pl;
    bus.ready_i   = rdy;
    bus.flush_i   = fl;
    nb.payload = pl;
    for (int l = 0; l < NO; l++) nb.ops[l] = resolve(bus.fwd_sel_i[l], bus.fwd_data_i, bus.op_i[l]);
    if (bus.valid_o && rdy && !fl) seen.push_back(bus.payload_o);
    if (mq.size() > 0 && !rdy) m_stall++;
    if (fl && (mq.size() > 0 || v)) m_flush++;
    acc = v && (mq.size() < 2);
    pop = (mq.size() > 0) && rdy;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(nb);
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic clear_operands();
    bus.op_i       = '0;
    bus.fwd_data_i = '0;
    bus.fwd_sel_i  = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 64'(bus.valid_o), 64'd0);
    check({tag, "_ready"}, 64'(bus.ready_o), 64'd1);
    check({tag, "_payload"}, bus.payload_o, 64'd0);
    check({tag, "_ops"}, 64'(bus.op_o), 64'd0);
    check({tag, "_stall"}, 64'(stall_cnt), 64'd0);
    check({tag, "_flush"}, 64'(flush_cnt), 64'd0);
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.payload_i = '0;
    bus.ready_i = 1'b0;
    bus.flush_i = 1'b0;
    clear_operands();

    // Reset state
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat straight through
    cycle(1'b1, 64'hA5, 1'b1, 1'b0);
    check("a5_payload", bus.payload_o, 64'hA5);
    check("a5_ready", 64'(bus.ready_o), 64'd1);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Stall at beat 2 fills the skid; upstream holds beat 3 until it is accepted
    seen.delete();
    cycle(1'b1, 64'd1, 1'b1, 1'b0);
    cycle(1'b1, 64'd2, 1'b0, 1'b0);
    check("skid_ready", 64'(bus.ready_o), 64'd0);
    cycle(1'b1, 64'd3, 1'b1, 1'b0);
    cycle(1'b1, 64'd3, 1'b1, 1'b0);
    cycle(1'b0, 64'd0, 1'b1, 1'b0);
    cycle(1'b0, 64'd0, 1'b1, 1'b0);
    check("order_cnt", 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      check("order_0", seen[0], 64'd1);
      check("order_1", seen[1], 64'd2);
      check("order_2", seen[2], 64'd3);
    end

    // Forwarding priority, then operands held stable against a changing network
    bus.fwd_sel_i[0]  = 2'b11;
    bus.fwd_data_i[1] = 32'h22;
    bus.fwd_data_i[0] = 32'h11;
    bus.op_i[0]       = 32'h99;
    cycle(1'b1, 64'd7, 1'b1, 1'b0);
    check("fwd_lowest", 64'(bus.op_o[0]), 64'h11);
    bus.fwd_sel_i[0] = 2'b00;
    cycle(1'b1, 64'd8, 1'b1, 1'b0);
    check("fwd_none", 64'(bus.op_o[0]), 64'h99);
    bus.fwd_sel_i[0]  = 2'b01;
    bus.fwd_data_i[0] = 32'h55;
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check("no_refwd", 64'(bus.op_o[0]), 64'h99);
    cycle(1'b0, 64'd0, 1'b1, 1'b0);
    clear_operands();

    // Flush from SKID with a same-cycle incoming beat
    cycle(1'b1, 64'd10, 1'b1, 1'b0);
    cycle(1'b1, 64'd11, 1'b0, 1'b0);
    cycle(1'b1, 64'd12, 1'b0, 1'b1);
    check("flush_valid", 64'(bus.valid_o), 64'd0);
    check("flush_ready", 64'(bus.ready_o), 64'd1);

    // Five stall cycles while FULL
    cycle(1'b1, 64'd20, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 64'd0, 1'b0, 1'b0);
      check("stall_hold", bus.payload_o, 64'd20);
    end
    cycle(1'b0, 64'd0, 1'b1, 1'b0);

    // Asynchronous reset while in SKID
    cycle(1'b1, 64'd30, 1'b1, 1'b0);
    cycle(1'b1, 64'd31, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    #1;
    check_reset_values("async_rst");
    mq.delete();
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 64'd0, 1'b1, 1'b0);
    cycle(1'b0, 64'd0, 1'b1, 1'b0);
    cycle(1'b1, 64'd32, 1'b1, 1'b0);
    check("post_rst_accept", bus.payload_o, 64'd32);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int l = 0; l < NO; l++) begin
        bus.op_i[l]      = $urandom;
        bus.fwd_sel_i[l] = NF'($urandom_range(0, (1 << NF) - 1));
      end
      for (int k = 0; k < NF; k++) bus.fwd_data_i[k] = $urandom;
      cycle($urandom_range(0, 9) < 7, {$urandom, $urandom},
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
